// File: rtl/board_io_irq.sv
// board_io_irq: memory-mapped board I/O with LEDs, 7-segment digits,
// synchronised switches, and buttons with press-event interrupts.
// The button debouncer is built only when BOARD_IO_IRQ_DEBOUNCE_EN is defined.
// Otherwise the stable button level is the synchronised input.
module board_io_irq #(
    parameter int N_LED        = 26,
    parameter int N_SW         = 18,
    parameter int N_BTN        = 4,
    parameter int N_HEX        = 8,
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               WE,
    input  logic [3:0]         A,
    input  logic [31:0]        WD,
    output logic [31:0]        RD,
    output logic               INT,
    input  logic [N_BTN-1:0]   BTNS,
    input  logic [N_SW-1:0]    DIP_SW,
    output logic [N_LED-1:0]   LEDS,
    output logic [8*N_HEX-1:0] HEX
);

    logic [N_LED-1:0]   led_reg;
    logic [4*N_HEX-1:0] hex_val_reg;
    logic [N_HEX-1:0]   blank_reg;
    logic [N_HEX-1:0]   dp_reg;
    logic [N_SW-1:0]    sw_meta_reg;
    logic [N_SW-1:0]    sw_sync_reg;
    logic [N_BTN-1:0]   btn_meta_reg;
    logic [N_BTN-1:0]   btn_sync_reg;
    logic [N_BTN-1:0]   btn_stable;
    logic [N_BTN-1:0]   btn_prev_reg;
    logic [N_BTN-1:0]   pend_reg;
    logic [N_BTN-1:0]   pend_next;
    logic [N_BTN-1:0]   mask_reg;
    logic [N_BTN-1:0]   w1c;
    logic [N_BTN-1:0]   press;

    // Only the low bits of each write are stored; the rest are ignored.
    logic unused_wd;
    assign unused_wd = ^WD;

    // Bus-writable control registers. The blank mask resets to all digits dark.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            led_reg     <= '0;
            hex_val_reg <= '0;
            blank_reg   <= '1;
            dp_reg      <= '0;
            mask_reg    <= '0;
        end else if (WE) begin
            case (A)
                4'd0: led_reg     <= WD[N_LED-1:0];
                4'd1: hex_val_reg <= WD[4*N_HEX-1:0];
                4'd2: begin
                    blank_reg <= WD[N_HEX-1:0];
                    dp_reg    <= WD[8+N_HEX-1:8];
                end
                4'd6: mask_reg    <= WD[N_BTN-1:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchronisers. Buttons are inverted first so that 1 means pressed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
        end else begin
            sw_meta_reg  <= DIP_SW;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= ~BTNS;
            btn_sync_reg <= btn_meta_reg;
        end
    end

`ifdef BOARD_IO_IRQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
        logic [CNT_W-1:0] cnt_reg;
        logic             stable_reg;

        // The stable level is accepted on the edge where the count would reach
        // DEBOUNCE_CYC. Any cycle where the input matches restarts the count.
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt_reg    <= '0;
                stable_reg <= 1'b0;
            end else if (btn_sync_reg[gi] == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
                stable_reg <= btn_sync_reg[gi];
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign btn_stable[gi] = stable_reg;
    end
`else
    // DEBOUNCE_CYC has no effect when the debouncer is not built.
    localparam int unused_debounce_cyc = DEBOUNCE_CYC;
    assign btn_stable = btn_sync_reg;
`endif

    assign press = btn_stable & ~btn_prev_reg;
    assign w1c   = (WE && (A == 4'd5)) ? WD[N_BTN-1:0] : '0;
    // The set term is ORed last, so a press wins over a clear in the same cycle.
    assign pend_next = (pend_reg & ~w1c) | press;

    // Press-edge history and the pending latch.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_prev_reg <= '0;
            pend_reg     <= '0;
        end else begin
            btn_prev_reg <= btn_stable;
            pend_reg     <= pend_next;
        end
    end

    assign INT  = |(pend_reg & mask_reg);
    assign LEDS = led_reg;

    // Read mux: zero-extended registers; unmapped addresses read 0.
    always_comb begin
        RD = '0;
        case (A)
            4'd0: RD[N_LED-1:0]     = led_reg;
            4'd1: RD[4*N_HEX-1:0]   = hex_val_reg;
            4'd2: begin
                RD[N_HEX-1:0]       = blank_reg;
                RD[8+N_HEX-1:8]     = dp_reg;
            end
            4'd3: RD[N_SW-1:0]      = sw_sync_reg;
            4'd4: RD[N_BTN-1:0]     = btn_stable;
            4'd5: RD[N_BTN-1:0]     = pend_reg;
            4'd6: RD[N_BTN-1:0]     = mask_reg;
            default: ;
        endcase
    end

    // Active-low {g..a} glyphs for hexadecimal digits 0-F.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Per-digit decode. Blanking overrides both the glyph and the decimal point.
    for (genvar gi = 0; gi < N_HEX; gi++) begin : g_hex
        assign HEX[8*gi +: 8] = blank_reg[gi] ? 8'hFF
                              : {~dp_reg[gi], seg7(hex_val_reg[4*gi +: 4])};
    end

endmodule

// File: tb/tb_board_io_irq.sv
// tb_board_io_irq: directed stimulus with a scoreboard queue. The stimulus
// pushes expected values, and a negedge monitor pops and compares them.
module tb_board_io_irq;
    localparam int N_LED = 26;
    localparam int N_SW  = 18;
    localparam int N_BTN = 4;
    localparam int N_HEX = 8;
    localparam int D     = 8;
`ifdef BOARD_IO_IRQ_DEBOUNCE_EN
    localparam int LAT = 2 + D;
`else
    localparam int LAT = 2;
`endif

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b1;
    logic               WE = 1'b0;
    logic [3:0]         A = '0;
    logic [31:0]        WD = '0;
    logic [31:0]        RD;
    logic               INT;
    logic [N_BTN-1:0]   BTNS = '1;
    logic [N_SW-1:0]    DIP_SW = '0;
    logic [N_LED-1:0]   LEDS;
    logic [8*N_HEX-1:0] HEX;

    board_io_irq #(
        .N_LED(N_LED), .N_SW(N_SW), .N_BTN(N_BTN), .N_HEX(N_HEX), .DEBOUNCE_CYC(D)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .A(A), .WD(WD), .RD(RD), .INT(INT),
        .BTNS(BTNS), .DIP_SW(DIP_SW), .LEDS(LEDS), .HEX(HEX)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;   // 0 RD, 1 LEDS, 2 HEX, 3 INT
        logic [63:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic expect_out(input string name, input int sel, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb_q.push_back(c);
    endtask

    task automatic expect_rd(input string name, input logic [3:0] a, input logic [63:0] exp);
        A = a;
        expect_out(name, 0, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        WE = 1'b1;
        A  = a;
        WD = d;
        step(1);
        WE = 1'b0;
    endtask

    // Monitor: compare every queued expectation against the outputs at the negedge.
    always @(negedge CLK) begin
        while (sb_q.size() > 0) begin
            chk_t        c;
            logic [63:0] act;
            c = sb_q.pop_front();
            case (c.sel)
                0:       act = {32'b0, RD};
                1:       act = {38'b0, LEDS};
                2:       act = HEX;
                default: act = {63'b0, INT};
            endcase
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
            end else begin
                $display("ok   %s: %0h", c.name, act);
            end
        end
    end

    initial begin
        BTNS   = 4'($urandom);
        DIP_SW = 18'($urandom);
        #2 RESET_N = 1'b0;
        step(2);
        // Reset state (checked while reset is held)
        expect_out("rst_leds", 1, 64'h0);
        expect_out("rst_hex", 2, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_out("rst_int", 3, 64'h0);
        expect_rd("rst_pend", 4'd5, 64'h0);
        step(1);
        expect_rd("rst_hexctl", 4'd2, 64'h0000_00FF);
        step(1);
        BTNS   = '1;
        DIP_SW = '0;
        step(2);
        RESET_N = 1'b1;
        step(3);

        // LED / HEX writes
        wr(4'd0, 32'hFFFF_FFFF);
        wr(4'd1, 32'h89AB_CDEF);
        wr(4'd2, 32'h0000_0100);
        expect_out("leds", 1, 64'h3FF_FFFF);
        expect_out("hex_dp0", 2, 64'h8090_8883_C6A1_860E);
        expect_rd("rd_led", 4'd0, 64'h03FF_FFFF);
        step(1);
        expect_rd("rd_hexval", 4'd1, 64'h89AB_CDEF);
        step(1);
        expect_rd("rd_hexctl", 4'd2, 64'h0000_0100);
        step(1);
        wr(4'd2, 32'h0000_FF01);
        expect_out("hex_blank", 2, 64'h0010_0803_4621_06FF);
        expect_rd("rd_hexctl2", 4'd2, 64'h0000_FF01);
        step(1);
        wr(4'd9, 32'hFFFF_FFFF);
        expect_rd("rd_reserved", 4'd9, 64'h0);
        step(1);
        wr(4'd3, 32'hFFFF_FFFF);
        expect_rd("rd_sw_ro", 4'd3, 64'h0);
        step(1);

        // Button press and its latency
        BTNS[1] = 1'b0;
        step(LAT - 1);
        expect_rd("btn_early", 4'd4, 64'h0);
        step(1);
        expect_rd("btn_set", 4'd4, 64'h2);
        step(1);
        expect_rd("pend_set", 4'd5, 64'h2);
        expect_out("int_masked", 3, 64'h0);
        step(1);

        // Mask and write-1-to-clear
        wr(4'd6, 32'h0000_0002);
        expect_out("int_unmask", 3, 64'h1);
        step(1);
        wr(4'd5, 32'h0000_0001);
        expect_out("int_w1c_other", 3, 64'h1);
        expect_rd("pend_keep", 4'd5, 64'h2);
        step(1);
        wr(4'd5, 32'h0000_0002);
        expect_out("int_w1c", 3, 64'h0);
        expect_rd("pend_clr", 4'd5, 64'h0);
        step(1);

        // Release does not set pending
        BTNS = '1;
        step(LAT + 2);
        expect_rd("rel_btn", 4'd4, 64'h0);
        step(1);
        expect_rd("rel_pend", 4'd5, 64'h0);
        step(1);

        // Press edge coincident with W1C of the same bit
        BTNS[1] = 1'b0;
        step(LAT);
        WE = 1'b1;
        A  = 4'd5;
        WD = 32'h0000_0002;
        step(1);
        WE = 1'b0;
        expect_rd("set_wins", 4'd5, 64'h2);
        expect_out("set_wins_int", 3, 64'h1);
        step(1);
        wr(4'd5, 32'h0000_0002);
        BTNS = '1;
        step(LAT + 2);

`ifdef BOARD_IO_IRQ_DEBOUNCE_EN
        // A glitch one cycle shorter than the debounce window is rejected
        BTNS[1] = 1'b0;
        step(D - 1);
        BTNS[1] = 1'b1;
        step(20);
        expect_rd("glitch_btn", 4'd4, 64'h0);
        step(1);
        expect_rd("glitch_pend", 4'd5, 64'h0);
        step(1);
`endif

        // Switch synchroniser latency
        DIP_SW = 18'h2A5A5;
        step(1);
        expect_rd("sw_1cyc", 4'd3, 64'h0);
        step(1);
        expect_rd("sw_2cyc", 4'd3, 64'h0002_A5A5);
        step(1);

        // Reset mid-debounce, button released during reset
        BTNS[1] = 1'b0;
        step(4);
        RESET_N = 1'b0;
        #1;
        expect_out("mid_rst_leds", 1, 64'h0);
        step(1);
        BTNS = '1;
        step(2);
        RESET_N = 1'b1;
        step(LAT + 5);
        expect_rd("post_rst_btn", 4'd4, 64'h0);
        step(1);
        expect_rd("post_rst_pend", 4'd5, 64'h0);
        expect_out("post_rst_int", 3, 64'h0);
        step(2);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_io_irq.md
# board_io_irq

Parametrised memory-mapped board I/O peripheral on the CPU data bus. It drives LEDs and 7-segment digits, and reads synchronised switches and debounced buttons. Each button has a press-event latch, with a mask and a level interrupt to the core. It generalises the fixed-width LED/HEX/switch block to configurable channel counts, per-button interrupts with write-1-to-clear, and digit blanking/decimal-point control.

## Interface
Parameters:
- N_LED, 26, LED count (1..32)
- N_SW, 18, switch count (1..32)
- N_BTN, 4, button count (1..8)
- N_HEX, 8, 7-segment digit count (1..8)
- DEBOUNCE_CYC, 65536, consecutive stable cycles required to accept a button change (>=2)

Ports:
- CLK  in  1  single system clock, all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- WE  in  1  bus write strobe
- A  in  4  word address
- WD  in  32  write data
- RD  out  32  read data, combinational from A; unmapped addresses read 0
- INT  out  1  level interrupt = |(IRQ_PEND & IRQ_MASK)
- BTNS  in  N_BTN  raw buttons, active-low at pin
- DIP_SW  in  N_SW  raw switches
- LEDS  out  N_LED  LED drive, active-high
- HEX  out  8*N_HEX  segments, digit i at [8i+7:8i], {dp,g..a}, active-low

## Operation
Register map (A):
- 0 LED RW: bits [N_LED-1:0]
- 1 HEX_VAL RW: nibble i = hex digit i, bits [4*N_HEX-1:0]
- 2 HEX_CTL RW: [7:0] blank mask (1 = all segments off incl. dp), [15:8] dp on
- 3 SW RO: two-flop-synchronised DIP_SW, zero-extended
- 4 BTN RO: debounced button level (1 = pressed)
- 5 IRQ_PEND R/W1C: bit i set on debounced press edge (0->1) of button i
- 6 IRQ_MASK RW: bit i enables button i into INT
- 7..15 reserved, writes ignored, reads 0

Rules:
- Buttons are inverted at input, then pass through a two-flop synchroniser, then the debouncer.
- Debouncer, per button: a counter counts while the synchronised input differs from the stable level. It clears to 0 when they match. When the counter reaches DEBOUNCE_CYC the stable level takes the input and the counter clears. Counter width is $clog2(DEBOUNCE_CYC+1).
- Press edge = stable level is 1 and its previous-cycle copy is 0. Release does not set pending.
- Set has priority over clear: an edge and a W1C on the same bit in the same cycle leaves the bit set.
- Writing 0 bits to IRQ_PEND has no effect. Writes to RO registers are ignored.
- Bits above each register's width are write-ignored and read 0.
- HEX decode: standard 0-F glyphs. Then blank forces segments to 8'hFF, and dp clears bit 7 unless the digit is blanked.

Reset (RESET_N low, async) clears:
- LED, HEX_VAL, IRQ_PEND, IRQ_MASK, all synchronisers, debounce counters and stable levels, all to 0.
- Exception: HEX_CTL resets to blank mask 8'hFF, dp 0.
- Resulting outputs: LEDS=0, HEX all 8'hFF, INT=0, RD reflects cleared registers.

Reset asserted mid-debounce discards the count. There is no press edge after release, because the stable level restarts at 0.

## Timing
- Register write visible on RD and the outputs on the cycle after the WE edge. LEDS/HEX are register-driven; the HEX decode is combinational from registers.
- Switch: 2 cycles pin to SW.
- Button: a pin held for 2 + DEBOUNCE_CYC cycles updates BTN. IRQ_PEND sets 1 cycle later, and INT follows combinationally.
- A glitch shorter than DEBOUNCE_CYC synchronised cycles produces no BTN change.
- W1C of the last masked pending bit drops INT the cycle after the write.
- Masking a pending bit drops INT the cycle after the write; the pending bit is kept.

## Configuration
- BOARD_IO_IRQ_DEBOUNCE_EN defined: debouncer as above.
- Undefined: no counters; the stable level equals the synchronised input. Button latency becomes 2 cycles to BTN and 3 to IRQ_PEND, and DEBOUNCE_CYC is ignored.

## Test plan
- Reset with random inputs -> LEDS=0, HEX=64'hFFFF_FFFF_FFFF_FFFF, INT=0; read A=5 -> 0, A=2 -> 32'h0000_00FF.
- Write A=0 32'hFFFF_FFFF, A=1 32'h89AB_CDEF, A=2 32'h0000_0100 -> LEDS=26'h3FF_FFFF. Digit0 shows F with dp, i.e. HEX[7:0]=8'h0E; other digits show their glyphs with dp off. Read A=0 -> 32'h03FF_FFFF.
- DEBOUNCE_CYC=8: BTNS[1] low for 5 cycles then high -> BTN=0, no pending. Then low for 20 cycles -> BTN[1]=1 at cycle 10, IRQ_PEND=4'b0010 at cycle 11.
- IRQ_MASK=0 with pending bit 1 -> INT=0. Write IRQ_MASK=4'b0010 -> INT=1. W1C 4'b0001 -> INT stays 1. W1C 4'b0010 -> INT=0 next cycle.
- Press edge coincident with W1C of the same bit -> bit reads 1 afterwards.
- Toggle DIP_SW to 18'h2A5A5 -> A=3 reads 32'h0002_A5A5 two cycles later. Assert RESET_N mid-debounce -> counters cleared, no spurious pending after release.
